// File: rtl/spike_class_decoder_pkg.sv
// rtl/spike_class_decoder_pkg.sv - shared constants and FSM state type for the spike class decoder
package spike_class_decoder_pkg;
  localparam int NUM_NEURONS = 8;
  localparam int CNT_W       = 8;
  localparam int IDX_W       = 3;
  localparam int WIN_W       = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    HOLD    = 2'd3
  } state_t;
endpackage

// File: rtl/spike_class_decoder_if.sv
// rtl/spike_class_decoder_if.sv - control, spike input and class result handshake bundle
interface spike_class_decoder_if;
  import spike_class_decoder_pkg::*;

  logic                   start;
  logic [WIN_W-1:0]       window_len;
  logic [NUM_NEURONS-1:0] spike_in;
  logic [IDX_W-1:0]       class_idx;
  logic [CNT_W-1:0]       class_count;
  logic                   no_spike;
  logic                   class_valid;
  logic                   class_ready;
  logic                   busy;

  modport master (
    input  start, window_len, spike_in, class_ready,
    output class_idx, class_count, no_spike, class_valid, busy
  );

  modport slave (
    output start, window_len, spike_in, class_ready,
    input  class_idx, class_count, no_spike, class_valid, busy
  );
endinterface

// File: rtl/spike_class_decoder_counter_bank.sv
// rtl/spike_class_decoder_counter_bank.sv - per-neuron saturating spike counters with indexed read port
module spike_counter_bank
  import spike_class_decoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [CNT_W-1:0]       rd_cnt
);
  logic [CNT_W-1:0] cnt_q [NUM_NEURONS];
  logic [CNT_W-1:0] cnt_d [NUM_NEURONS];

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (en && spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_cnt = cnt_q[rd_idx];
endmodule

// File: rtl/spike_class_decoder.sv
// rtl/spike_class_decoder.sv - windowed spike counting followed by a sequential argmax over neurons
module spike_class_decoder
  import spike_class_decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  spike_class_decoder_if.master bus
);
  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             no_spike_q, no_spike_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] rd_cnt;
  logic             cand_wins;
  logic [IDX_W-1:0] nxt_best_idx;
  logic [CNT_W-1:0] nxt_best_cnt;

  spike_counter_bank u_bank (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .spike_in (bus.spike_in),
    .rd_idx   (cmp_idx_q),
    .rd_cnt   (rd_cnt)
  );

  // Strict greater-than keeps the earliest (lowest) index on ties.
  always_comb begin
    cand_wins    = rd_cnt > best_cnt_q;
    nxt_best_idx = cand_wins ? cmp_idx_q : best_idx_q;
    nxt_best_cnt = cand_wins ? rd_cnt : best_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    win_cnt_d  = win_cnt_q;
    cmp_idx_d  = cmp_idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    res_idx_d  = res_idx_q;
    res_cnt_d  = res_cnt_q;
    no_spike_d = no_spike_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_clr   = 1'b1;
          win_len_d = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
          win_cnt_d = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        cnt_en    = 1'b1;
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == win_len_q - 1'b1) begin
          cmp_idx_d  = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        best_idx_d = nxt_best_idx;
        best_cnt_d = nxt_best_cnt;
        cmp_idx_d  = cmp_idx_q + 1'b1;
        if (cmp_idx_q == IDX_W'(NUM_NEURONS - 1)) begin
          res_idx_d  = nxt_best_idx;
          res_cnt_d  = nxt_best_cnt;
          no_spike_d = (nxt_best_cnt == '0);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.class_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      cmp_idx_q  <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      no_spike_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      win_cnt_q  <= win_cnt_d;
      cmp_idx_q  <= cmp_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      res_idx_q  <= res_idx_d;
      res_cnt_q  <= res_cnt_d;
      no_spike_q <= no_spike_d;
    end
  end

  assign bus.class_valid = (state_q == HOLD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.class_idx   = res_idx_q;
  assign bus.class_count = res_cnt_q;
  assign bus.no_spike    = no_spike_q;
endmodule

// File: tb/tb_spike_class_decoder.sv
// tb/tb_spike_class_decoder.sv - randomized bench for spike_class_decoder against a window/argmax model
module tb_spike_class_decoder;
  import spike_class_decoder_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  spike_class_decoder_if bus ();

  spike_class_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 window+compare in progress, 2 result held.
  int m_phase = 0;
  int m_t     = 0;
  int m_w     = 1;
  int m_cnt [NUM_NEURONS];
  int m_best  = 0;
  int e_idx   = 0;
  int e_cnt   = 0;
  int e_ns    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      e_idx   = 0;
      e_cnt   = 0;
      e_ns    = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_w = (bus.window_len == 0) ? 1 : int'(bus.window_len);
          m_t = 0;
          foreach (m_cnt[i]) m_cnt[i] = 0;
          m_phase = 1;
        end
        1: begin
          m_t++;
          if (m_t <= m_w) begin
            foreach (m_cnt[i]) begin
              if (bus.spike_in[i]) m_cnt[i] = (m_cnt[i] < (1 << CNT_W) - 1) ? m_cnt[i] + 1 : m_cnt[i];
            end
          end
          if (m_t == m_w + NUM_NEURONS) begin
            m_best = 0;
            foreach (m_cnt[i]) if (m_cnt[i] > m_cnt[m_best]) m_best = i;
            e_idx   = m_best;
            e_cnt   = m_cnt[m_best];
            e_ns    = (e_cnt == 0) ? 1 : 0;
            m_phase = 2;
          end
        end
        default: if (bus.class_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("class_valid", bus.class_valid, (m_phase == 2) ? 1 : 0);
      chk("busy", bus.busy, (m_phase != 0) ? 1 : 0);
      chk("class_idx", bus.class_idx, e_idx);
      chk("class_count", bus.class_count, e_cnt);
      chk("no_spike", bus.no_spike, e_ns);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.class_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_idx"}, bus.class_idx, 0);
    chk({tag, "_count"}, bus.class_count, 0);
    chk({tag, "_no_spike"}, bus.no_spike, 0);
  endtask

  function automatic logic [NUM_NEURONS-1:0] pat(input int mode, input int k, input int wl);
    logic [NUM_NEURONS-1:0] s;
    s = NUM_NEURONS'($urandom);
    if (k <= wl) begin
      case (mode)
        0: s = 8'h04 | ((k == 2 || k == 5 || k == 7) ? 8'h01 : 8'h00);
        1: s = 8'h82;
        2: s = 8'h00;
        3: s = 8'h80 | ((k <= 100) ? 8'h01 : 8'h00);
        4: s = NUM_NEURONS'($urandom & $urandom);
        default: s = NUM_NEURONS'($urandom | $urandom);
      endcase
    end
    return s;
  endfunction

  task automatic do_window(input int w, input int mode, input int hold_wait, input bit junk,
                           input int lit_idx, input int lit_cnt, input int lit_ns);
    int lat;
    int wl;
    wl = (w == 0) ? 1 : w;
    bus.start      = 1'b1;
    bus.window_len = WIN_W'(w);
    bus.spike_in   = NUM_NEURONS'($urandom);
    step();
    bus.start      = 1'b0;
    bus.window_len = WIN_W'($urandom);
    lat = 1;
    while (!bus.class_valid && lat < wl + 40) begin
      bus.spike_in = pat(mode, lat, wl);
      bus.start    = junk && (lat == 2);
      step();
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", lat, wl + NUM_NEURONS + 1);
    if (lit_idx >= 0) begin
      chk("lit_class_idx", bus.class_idx, lit_idx);
      chk("lit_class_count", bus.class_count, lit_cnt);
      chk("lit_no_spike", bus.no_spike, lit_ns);
    end
    for (int h = 0; h < hold_wait; h++) begin
      bus.class_ready = 1'b0;
      bus.spike_in    = NUM_NEURONS'($urandom);
      bus.start       = junk && (h == 1);
      step();
    end
    bus.start       = 1'b0;
    bus.class_ready = 1'b1;
    step();
    bus.class_ready = 1'b0;
    chk("valid_after_ready", bus.class_valid, 0);
    chk("busy_after_ready", bus.busy, 0);
    step();
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.window_len  = '0;
    bus.spike_in    = '0;
    bus.class_ready = 1'b0;
    #1;
    chk_zero("reset");
    repeat (3) step();
    reset_n = 1'b1;
    step();

    do_window(10, 0, 0, 1'b0, 2, 10, 0);
    do_window(4, 1, 0, 1'b0, 1, 4, 0);
    do_window(5, 2, 0, 1'b0, 0, 0, 1);
    do_window(300, 3, 0, 1'b0, 7, 255, 0);
    do_window(12, 4, 5, 1'b1, -1, 0, 0);
    do_window(0, 5, 1, 1'b1, -1, 0, 0);
    for (int r = 0; r < 8; r++) begin
      do_window(int'($urandom_range(0, 40)), 4 + (r % 2), int'($urandom_range(0, 3)), 1'b1, -1, 0, 0);
    end

    // Reset pulse partway through an accumulation window.
    bus.start      = 1'b1;
    bus.window_len = WIN_W'(20);
    step();
    bus.start = 1'b0;
    repeat (6) begin
      bus.spike_in = NUM_NEURONS'($urandom);
      step();
    end
    #5 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    #1 reset_n = 1'b1;
    repeat (40) begin
      bus.spike_in = NUM_NEURONS'($urandom);
      step();
    end
    do_window(10, 0, 0, 1'b0, 2, 10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_class_decoder.md
Name: spike_class_decoder

Overview:
- Downstream consumer of the 8-lane SNN controller's output_spike bus.
- Counts spikes per output neuron over a programmable time window, then selects the winning neuron (argmax of counts) sequentially.
- Presents the result as a class index with a valid/ready handshake to the host or readout logic.

Parameters:
- NUM_NEURONS, 8, number of spike lanes / classes.
- CNT_W, 8, per-neuron spike counter width; counters saturate.
- IDX_W, 3, class index width, equal to clog2(NUM_NEURONS).
- WIN_W, 16, window length register width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a classification window; accepted only in IDLE.
- window_len  in  WIN_W  window length in cycles; sampled on accepted start.
- spike_in  in  NUM_NEURONS  spike bus from the controller (output_spike); bit i = neuron i fired this cycle.
- class_idx  out  IDX_W  winning neuron index.
- class_count  out  CNT_W  spike count of the winner.
- no_spike  out  1  set with the result when every count is 0.
- class_valid  out  1  result valid.
- class_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all of the following go to 0 immediately and asynchronously:
  - class_idx, class_count, no_spike, class_valid, busy
  - all counters
  - the window counter
  - the FSM, which enters IDLE.
- FSM states and transitions:
  - IDLE: start=1 clears all counters, latches window_len (0 is treated as 1), and moves to ACCUM. start in any other state is ignored.
  - ACCUM: each cycle, for every i with spike_in[i]=1, count[i] += 1, saturating at 2^CNT_W-1. The window counter increments each cycle. After exactly window_len ACCUM cycles, the FSM moves to COMPARE. Spikes on the first ACCUM cycle (the cycle after start) are counted. Spikes on the start cycle itself are not counted.
  - COMPARE: one neuron examined per cycle, index 0 to NUM_NEURONS-1. The running best is replaced only on a strictly greater count, so ties resolve to the lowest index. After the last neuron is examined, the result registers load and the FSM moves to HOLD.
  - HOLD: class_valid=1 and outputs are stable. When class_valid && class_ready on a rising edge, the result is consumed: class_valid drops the next cycle and the FSM moves to IDLE. class_ready held high from entry completes the transaction in the first HOLD cycle.
- Latency: from the start cycle to class_valid is window_len + NUM_NEURONS + 1 cycles.
- All-zero counts: class_idx=0, class_count=0, no_spike=1.
- spike_in is ignored outside ACCUM.
- Counters keep their values after the window until the next accepted start.
- Reset mid-ACCUM or mid-HOLD: the result is lost, no spurious class_valid is produced, and the block returns to IDLE.
- class_idx, class_count and no_spike change only when entering HOLD.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, ACCUM=2'd1, COMPARE=2'd2, HOLD=2'd3
  - default constants NUM_NEURONS, CNT_W, IDX_W
  - saturating-max constant CNT_MAX.
- Sub-module spike_counter_bank: NUM_NEURONS saturating counters with clear and enable, plus a read mux by index.
- FSM and comparator stay in the top module.

Test Plan:
- Basic win: window_len=10; spike_in=8'b0000_0100 every cycle, plus 8'b0000_0001 on 3 cycles. Required: class_idx=2, class_count=10, no_spike=0, class_valid asserted 19 cycles after start.
- Tie: window_len=4; spike_in=8'b1000_0010 every cycle. Required: class_idx=1, class_count=4.
- Silence: window_len=5, spike_in=0. Required: no_spike=1, class_idx=0, class_count=0.
- Saturation: window_len=300; lane 7 high every cycle, lane 0 high on 100 cycles. Required: class_idx=7, class_count=255.
- Handshake and start filtering:
  - class_ready=0 for 5 HOLD cycles: class_valid and outputs held stable throughout.
  - start pulsed during ACCUM and during HOLD: ignored.
  - class_ready=1: class_valid low the next cycle and busy=0.
- Reset mid-ACCUM: reset_n low for 2 ns mid-window. Required: all outputs 0 immediately and asynchronously, and no class_valid afterwards. A new start then classifies correctly with counts beginning from 0.
